// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider with shadowed divisor/mode
// and a shared phase-align strobe.
module clock_divider_mc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk_in,
    input  logic                      nrst,
    input  logic [CHANNELS*WIDTH-1:0] scale,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       wrap
);

    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q [CHANNELS];
    logic [WIDTH-1:0] cnt_d [CHANNELS];
    logic [WIDTH-1:0] div_q [CHANNELS];
    logic [WIDTH-1:0] div_d [CHANNELS];
    logic [WIDTH-1:0] deff  [CHANNELS];
    logic [WIDTH-1:0] last  [CHANNELS];
    logic [WIDTH-1:0] half  [CHANNELS];
    logic [WIDTH-1:0] inc   [CHANNELS];

    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] run_q, run_d;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] wrap_q, wrap_d;

    // half is ceil(deff/2) without needing a WIDTH+1 bit sum
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign deff[g] = (div_q[g] < TWO) ? TWO : div_q[g];
        assign last[g] = deff[g] - ONE;
        assign half[g] = (deff[g] >> 1) + {{(WIDTH-1){1'b0}}, deff[g][0]};
        assign inc[g]  = cnt_q[g] + ONE;
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]     = cnt_q[c];
            div_d[c]     = div_q[c];
            mode_d[c]    = mode_q[c];
            run_d[c]     = run_q[c];
            clk_out_d[c] = clk_out_q[c];
            wrap_d[c]    = wrap_q[c];
            if (!en[c]) begin
                cnt_d[c]     = '0;
                run_d[c]     = 1'b0;
                clk_out_d[c] = 1'b0;
                wrap_d[c]    = 1'b0;
            end else if (sync || !run_q[c] || cnt_q[c] == last[c]) begin
                // Reload point: new divisor is always >= 2, so no wrap here
                div_d[c]     = scale[c*WIDTH +: WIDTH];
                mode_d[c]    = mode[c];
                cnt_d[c]     = '0;
                run_d[c]     = 1'b1;
                clk_out_d[c] = 1'b1;
                wrap_d[c]    = 1'b0;
            end else begin
                cnt_d[c]     = inc[c];
                clk_out_d[c] = mode_q[c] ? (inc[c] == '0) : (inc[c] < half[c]);
                wrap_d[c]    = (inc[c] == last[c]);
            end
        end
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
                div_q[c] <= TWO;
            end
            mode_q    <= '0;
            run_q     <= '0;
            clk_out_q <= '0;
            wrap_q    <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= cnt_d[c];
                div_q[c] <= div_d[c];
            end
            mode_q    <= mode_d;
            run_q     <= run_d;
            clk_out_q <= clk_out_d;
            wrap_q    <= wrap_d;
        end
    end

    assign clk_out = clk_out_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_clock_divider_mc.sv
// Scoreboard bench for clock_divider_mc: a period/position model pushes
// the expected {clk_out,wrap} per edge, compared one unit after the edge.
module tb_clock_divider_mc;

    localparam int W  = 8;
    localparam int CH = 2;

    logic          clk_in = 1'b0;
    logic          nrst;
    logic [CH*W-1:0] scale;
    logic [CH-1:0] mode;
    logic [CH-1:0] en;
    logic          sync;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] wrap;

    clock_divider_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk_in  (clk_in),
        .nrst    (nrst),
        .scale   (scale),
        .mode    (mode),
        .en      (en),
        .sync    (sync),
        .clk_out (clk_out),
        .wrap    (wrap)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] sb[$];

    int m_pos   [CH];
    int m_per   [CH];
    bit m_run   [CH];
    bit m_pulse [CH];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_out(input int i);
        logic [1:0] o;
        o = 2'b00;
        if (m_run[i]) begin
            o[1] = m_pulse[i] ? (m_pos[i] == 0) : (2 * m_pos[i] < m_per[i]);
            o[0] = (m_pos[i] == m_per[i] - 1);
        end
        return o;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < CH; i++) begin
            m_run[i]   = 1'b0;
            m_pos[i]   = 0;
            m_per[i]   = 2;
            m_pulse[i] = 1'b0;
        end
    endtask

    task automatic m_load(input int i);
        int s;
        s          = int'(scale[i*W +: W]);
        m_per[i]   = (s < 2) ? 2 : s;
        m_pulse[i] = mode[i];
        m_pos[i]   = 0;
        m_run[i]   = 1'b1;
    endtask

    task automatic m_edge();
        logic [1:0] o0, o1;
        if (!nrst) begin
            m_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!en[i]) begin
                    m_run[i] = 1'b0;
                    m_pos[i] = 0;
                end else if (sync || !m_run[i]) begin
                    m_load(i);
                end else if (m_pos[i] == m_per[i] - 1) begin
                    m_load(i);
                end else begin
                    m_pos[i]++;
                end
            end
        end
        o0 = m_out(0);
        o1 = m_out(1);
        sb.push_back({o1[1], o0[1], o1[0], o0[0]});
    endtask

    task automatic step(input string tag);
        logic [3:0] e;
        m_edge();
        @(posedge clk_in);
        #1;
        e = sb.pop_front();
        check(tag, {28'd0, clk_out, wrap}, {28'd0, e});
    endtask

    task automatic steps(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        nrst  = 1'b1;
        scale = '0;
        mode  = '0;
        en    = '0;
        sync  = 1'b0;
        m_reset();
        #1 nrst = 1'b0;
        #1;
        check("rst_clk_out", {30'd0, clk_out}, 32'd0);
        check("rst_wrap", {30'd0, wrap}, 32'd0);
        steps(2, "in_reset");
        nrst = 1'b1;
        steps(2, "idle");

        // basic divide
        scale = {8'd6, 8'd3};
        en    = 2'b11;
        step("start");
        check("start_both_high", {30'd0, clk_out}, 32'd3);
        steps(12, "basic");

        // glitch-free scale change on second cycle of a ch0 period
        for (int k = 0; k < 6 && m_pos[0] != 1; k++) step("align_gf");
        check("gf_reached", m_pos[0], 1);
        scale[7:0] = 8'd6;
        steps(16, "glitch_free");

        // degenerate divisors, then pulse mode
        en = 2'b00;
        step("stop");
        scale = {8'd1, 8'd0};
        en    = 2'b11;
        steps(8, "deg_div");
        mode  = 2'b11;
        scale = {8'd4, 8'd4};
        steps(12, "pulse");

        // phase alignment
        en    = 2'b00;
        mode  = 2'b00;
        scale = {8'd6, 8'd4};
        step("stop2");
        en = 2'b01;
        steps(2, "ch0_only");
        en = 2'b11;
        steps(3, "offset");
        sync = 1'b1;
        step("sync");
        check("sync_aligned", {30'd0, clk_out}, 32'd3);
        sync = 1'b0;
        steps(12, "post_sync");

        // async reset mid-run
        scale = {8'd6, 8'd6};
        for (int k = 0; k < 8 && m_out(0) != 2'b10; k++) step("align_rst");
        check("rst_pre_high", {31'd0, clk_out[0]}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("arst_clk_out", {30'd0, clk_out}, 32'd0);
        check("arst_wrap", {30'd0, wrap}, 32'd0);
        m_reset();
        step("arst_hold");
        nrst = 1'b1;
        step("arst_release");
        check("arst_first_high", {30'd0, clk_out}, 32'd3);
        steps(8, "arst_run");

        // enable control
        for (int k = 0; k < 8 && m_pos[1] != 1; k++) step("align_en");
        check("en_mid_high", {31'd0, clk_out[1]}, 32'd1);
        en = 2'b01;
        step("disable1");
        check("disable1_low", {31'd0, clk_out[1]}, 32'd0);
        sync = 1'b1;
        step("sync_disabled");
        check("sync_disabled_low", {31'd0, clk_out[1]}, 32'd0);
        sync = 1'b0;
        steps(4, "ch1_idle");

        // random traffic
        for (int k = 0; k < 80; k++) begin
            en    = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            scale = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
            mode  = 2'($urandom);
            sync  = ($urandom_range(0, 7) == 0);
            step("random");
        end
        sync = 1'b0;

        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
